svc_axi_arbiter_rd_qos: RTL and testbench
=========================================

Name: svc_axi_arbiter_rd_qos

Overview:
- Parametrised read-channel arbiter from NUM_M AXI managers to one AXI subordinate.
- Adds the following to the basic N:1 read arbiter:
  - selectable round-robin or fixed-priority arbitration;
  - multiple outstanding bursts per manager, bounded by per-manager credit counters;
  - full-throughput back-to-back AR forwarding through a registered AR stage.
- Sits between the cache/DMA read ports and the memory controller read port.

Parameters:
NUM_M, 4, number of upstream managers (must be >= 2)
AXI_ADDR_WIDTH, 8, address width
AXI_DATA_WIDTH, 16, data width
AXI_ID_WIDTH, 4, upstream ID width
M_AXI_ID_WIDTH, AXI_ID_WIDTH+$clog2(NUM_M), downstream ID width; the manager index is placed in the MSBs
MAX_OUTSTANDING, 4, maximum in-flight AR bursts per manager (>= 1)
ARB_MODE, 0, 0 = round robin, 1 = fixed priority (index 0 highest)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_axi_arvalid  in  [NUM_M]  per-manager AR valid
s_axi_arid  in  [NUM_M][AXI_ID_WIDTH]  AR ID
s_axi_araddr  in  [NUM_M][AXI_ADDR_WIDTH]  AR address
s_axi_arlen / arsize / arburst  in  [NUM_M][8]/[3]/[2]  burst attributes
s_axi_arready  out  [NUM_M]  AR accept
s_axi_rvalid  out  [NUM_M]  R valid
s_axi_rid  out  [NUM_M][AXI_ID_WIDTH]  R ID with the index stripped
s_axi_rdata  out  [NUM_M][AXI_DATA_WIDTH]  R data
s_axi_rresp  out  [NUM_M][2]  R response
s_axi_rlast  out  [NUM_M]  R last
s_axi_rready  in  [NUM_M]  R ready
m_axi_arvalid  out  1  downstream AR valid (registered)
m_axi_arid  out  M_AXI_ID_WIDTH  {grant index, s_axi_arid}
m_axi_araddr / arlen / arsize / arburst  out  as above  registered AR payload
m_axi_arready  in  1  downstream AR ready
m_axi_rvalid / rid / rdata / rresp / rlast  in  as above  downstream R
m_axi_rready  out  1  downstream R ready

Behaviour:
- Reset:
  - m_axi_arvalid = 0 and all AR payload registers = 0.
  - All outstanding counters = 0.
  - RR pointer = NUM_M-1, so manager 0 wins first.
  - s_axi_arready = 0, s_axi_rvalid = 0.
  - Reset mid-burst drops all in-flight state; the downstream subordinate must be reset with it.
- AR stage load condition: load_en = !m_axi_arvalid || m_axi_arready.
  - The AR register may therefore refill in the same cycle it drains, giving 1 AR per cycle sustained.
- Eligibility: eligible[i] = s_axi_arvalid[i] && (outstanding[i] < MAX_OUTSTANDING).
- Grant:
  - ARB_MODE 0: first eligible index starting at rr_ptr+1 and wrapping modulo NUM_M.
  - ARB_MODE 1: lowest eligible index.
- Acceptance:
  - When load_en and any eligible manager: s_axi_arready[g] = 1 combinationally in that cycle; all other arready = 0.
  - On that edge: payload is captured, m_axi_arvalid <= 1, m_axi_arid <= {g, s_axi_arid[g]}, and rr_ptr <= g.
  - rr_ptr changes only on a grant.
- Idle/stall: when load_en is true and nothing is eligible, m_axi_arvalid <= 0. While stalled (arvalid && !arready), the payload is held stable.
- Outstanding counter i (width $clog2(MAX_OUTSTANDING+1)):
  - +1 on s-side AR handshake for i.
  - -1 on an R handshake with rlast routed to i.
  - Both in the same cycle: unchanged.
  - At MAX_OUTSTANDING, manager i is masked even if arvalid is asserted. The counter never exceeds MAX or underflows.
- R routing (combinational, zero latency):
  - idx = m_axi_rid[M_AXI_ID_WIDTH-1 -: $clog2(NUM_M)].
  - s_axi_rvalid[i] = m_axi_rvalid && idx == i.
  - rid/rdata/rresp/rlast are broadcast; rid is the low AXI_ID_WIDTH bits.
  - m_axi_rready = s_axi_rready[idx].
  - idx >= NUM_M (non-power-of-2 NUM_M): m_axi_rready = 1, the beat is dropped, and no counter changes.
- R beats of different managers may interleave per AXI ID rules. Only rlast affects the counters.

Optional Feature:
- Macro: SVC_AXI_ARB_STATS_EN.
- When defined:
  - Adds output stat_grants [NUM_M][16]: per-manager grant counters, +1 per AR grant, saturating at 0xFFFF.
  - Adds output stat_stall [NUM_M][16]: counts cycles where s_axi_arvalid[i] && !s_axi_arready[i], saturating.
  - Adds input stat_clr [1]: synchronous clear. If stat_clr and an increment coincide, the counter becomes 0.
  - Reset clears all counters to 0.
- When undefined: the ports and logic are absent and the behaviour is otherwise identical.

Test Plan:
- RR fairness: ARB_MODE=0, all 4 managers hold arvalid continuously with m_axi_arready=1 and R returned promptly -> grant order 0,1,2,3,0,1..., m_axi_arvalid high every cycle after the first, and m_axi_arid MSBs follow the same sequence.
- Fixed priority: ARB_MODE=1, managers 1 and 3 both valid -> manager 1 granted every cycle; manager 3 is granted only once manager 1 reaches MAX_OUTSTANDING=4 (5th request blocked).
- Credit limit: manager 2 issues 4 ARs with no R returned -> the 5th is held with s_axi_arready[2]=0; a single rlast beat with rid={2,x} unblocks exactly one AR on the next cycle.
- Stall hold: m_axi_arready=0 for 5 cycles after a grant -> m_axi_araddr/arid stable, no further s_axi_arready asserted; on release, the next grant is loaded in the same cycle.
- R routing: m_axi_rid={3,4'hA}, rlast=1, s_axi_rready[3]=0 for 2 cycles -> s_axi_rvalid[3]=1 with rid 4'hA, m_axi_rready=0 until released, then the outstanding[3] decrement is observed.
- Reset mid-operation: rst asserted with 3 ARs outstanding and m_axi_arvalid=1 -> next cycle m_axi_arvalid=0 and counters 0; first post-reset grant goes to manager 0.

Source files
------------

// File: rtl/svc_axi_arbiter_rd_qos.sv
// N:1 AXI read arbiter with round-robin/fixed-priority grant, per-manager credit limits and a registered AR stage.
// Optional per-manager grant/stall statistics are enabled by defining SVC_AXI_ARB_STATS_EN.
module svc_axi_arbiter_rd_qos #(
  parameter int NUM_M           = 4,
  parameter int AXI_ADDR_WIDTH  = 8,
  parameter int AXI_DATA_WIDTH  = 16,
  parameter int AXI_ID_WIDTH    = 4,
  parameter int M_AXI_ID_WIDTH  = AXI_ID_WIDTH + $clog2(NUM_M),
  parameter int MAX_OUTSTANDING = 4,
  parameter int ARB_MODE        = 0
) (
  input  logic                                         clk,
  input  logic                                         rst,
`ifdef SVC_AXI_ARB_STATS_EN
  input  logic                                         stat_clr,
  output logic [NUM_M-1:0][15:0]                       stat_grants,
  output logic [NUM_M-1:0][15:0]                       stat_stall,
`endif
  input  logic [NUM_M-1:0]                             s_axi_arvalid,
  input  logic [NUM_M-1:0][AXI_ID_WIDTH-1:0]           s_axi_arid,
  input  logic [NUM_M-1:0][AXI_ADDR_WIDTH-1:0]         s_axi_araddr,
  input  logic [NUM_M-1:0][7:0]                        s_axi_arlen,
  input  logic [NUM_M-1:0][2:0]                        s_axi_arsize,
  input  logic [NUM_M-1:0][1:0]                        s_axi_arburst,
  output logic [NUM_M-1:0]                             s_axi_arready,
  output logic [NUM_M-1:0]                             s_axi_rvalid,
  output logic [NUM_M-1:0][AXI_ID_WIDTH-1:0]           s_axi_rid,
  output logic [NUM_M-1:0][AXI_DATA_WIDTH-1:0]         s_axi_rdata,
  output logic [NUM_M-1:0][1:0]                        s_axi_rresp,
  output logic [NUM_M-1:0]                             s_axi_rlast,
  input  logic [NUM_M-1:0]                             s_axi_rready,
  output logic                                         m_axi_arvalid,
  output logic [M_AXI_ID_WIDTH-1:0]                    m_axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0]                    m_axi_araddr,
  output logic [7:0]                                   m_axi_arlen,
  output logic [2:0]                                   m_axi_arsize,
  output logic [1:0]                                   m_axi_arburst,
  input  logic                                         m_axi_arready,
  input  logic                                         m_axi_rvalid,
  input  logic [M_AXI_ID_WIDTH-1:0]                    m_axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0]                    m_axi_rdata,
  input  logic [1:0]                                   m_axi_rresp,
  input  logic                                         m_axi_rlast,
  output logic                                         m_axi_rready
);

  localparam int IDX_W = $clog2(NUM_M);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [NUM_M-1:0][CNT_W-1:0] outstanding;
  logic [NUM_M-1:0]            eligible;
  logic [NUM_M-1:0]            r_done;
  logic [IDX_W-1:0]            rr_ptr;
  logic [IDX_W-1:0]            gnt_idx;
  logic [IDX_W-1:0]            cand_idx;
  logic [IDX_W-1:0]            r_idx;
  logic                        gnt_found;
  logic                        load_en;
  int                          cand;

  // The AR register refills in the same cycle it drains, sustaining one AR per cycle.
  assign load_en = !m_axi_arvalid || m_axi_arready;

  always_comb begin
    for (int i = 0; i < NUM_M; i++)
      eligible[i] = s_axi_arvalid[i] && (outstanding[i] < CNT_W'(MAX_OUTSTANDING));
  end

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    if (ARB_MODE == 1) begin
      for (int i = NUM_M - 1; i >= 0; i--) begin
        if (eligible[i]) begin
          gnt_found = 1'b1;
          gnt_idx   = IDX_W'(i);
        end
      end
    end else begin
      for (int k = 1; k <= NUM_M; k++) begin
        cand     = (int'(rr_ptr) + k) % NUM_M;
        cand_idx = IDX_W'(cand);
        if (!gnt_found && eligible[cand_idx]) begin
          gnt_found = 1'b1;
          gnt_idx   = cand_idx;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_M; i++)
      s_axi_arready[i] = !rst && load_en && gnt_found && (gnt_idx == IDX_W'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_axi_arvalid <= 1'b0;
      m_axi_arid    <= '0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_arsize  <= '0;
      m_axi_arburst <= '0;
      rr_ptr        <= IDX_W'(NUM_M - 1);
    end else if (load_en) begin
      if (gnt_found) begin
        m_axi_arvalid <= 1'b1;
        m_axi_arid    <= M_AXI_ID_WIDTH'({gnt_idx, s_axi_arid[gnt_idx]});
        m_axi_araddr  <= s_axi_araddr[gnt_idx];
        m_axi_arlen   <= s_axi_arlen[gnt_idx];
        m_axi_arsize  <= s_axi_arsize[gnt_idx];
        m_axi_arburst <= s_axi_arburst[gnt_idx];
        rr_ptr        <= gnt_idx;
      end else begin
        m_axi_arvalid <= 1'b0;
      end
    end
  end

  // R beats route by the manager index held in the ID MSBs; unknown indices are sunk.
  assign r_idx = m_axi_rid[M_AXI_ID_WIDTH-1 -: IDX_W];

  always_comb begin
    m_axi_rready = 1'b1;
    s_axi_rvalid = '0;
    for (int i = 0; i < NUM_M; i++) begin
      s_axi_rid[i]   = m_axi_rid[AXI_ID_WIDTH-1:0];
      s_axi_rdata[i] = m_axi_rdata;
      s_axi_rresp[i] = m_axi_rresp;
      s_axi_rlast[i] = m_axi_rlast;
      if (r_idx == IDX_W'(i)) begin
        m_axi_rready    = s_axi_rready[i];
        s_axi_rvalid[i] = m_axi_rvalid && !rst;
      end
      r_done[i] = s_axi_rvalid[i] && s_axi_rready[i] && m_axi_rlast;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_M; i++) begin
      if (rst) begin
        outstanding[i] <= '0;
      end else if (s_axi_arready[i] && !r_done[i]) begin
        if (outstanding[i] < CNT_W'(MAX_OUTSTANDING))
          outstanding[i] <= outstanding[i] + CNT_W'(1);
      end else if (r_done[i] && !s_axi_arready[i]) begin
        if (outstanding[i] != '0)
          outstanding[i] <= outstanding[i] - CNT_W'(1);
      end
    end
  end

`ifdef SVC_AXI_ARB_STATS_EN
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_M; i++) begin
      if (rst || stat_clr) begin
        stat_grants[i] <= '0;
        stat_stall[i]  <= '0;
      end else begin
        if (s_axi_arready[i] && stat_grants[i] != 16'hFFFF)
          stat_grants[i] <= stat_grants[i] + 16'd1;
        if (s_axi_arvalid[i] && !s_axi_arready[i] && stat_stall[i] != 16'hFFFF)
          stat_stall[i] <= stat_stall[i] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_svc_axi_arbiter_rd_qos.sv
// Directed bench for svc_axi_arbiter_rd_qos: one round-robin and one fixed-priority instance share stimulus.
module tb_svc_axi_arbiter_rd_qos;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]       arvalid;
  logic [3:0][3:0]  arid;
  logic [3:0][7:0]  araddr;
  logic [3:0][7:0]  arlen;
  logic [3:0][2:0]  arsize;
  logic [3:0][1:0]  arburst;
  logic [3:0]       rready_s;
  logic             m_arready, m_rvalid, m_rlast;
  logic [5:0]       m_rid;
  logic [15:0]      m_rdata;
  logic [1:0]       m_rresp;

  logic [3:0]       arready_rr, rvalid_rr, rlast_rr, arready_fp, rvalid_fp, rlast_fp;
  logic [3:0][3:0]  rid_rr, rid_fp;
  logic [3:0][15:0] rdata_rr, rdata_fp;
  logic [3:0][1:0]  rresp_rr, rresp_fp;
  logic             marvalid_rr, mrready_rr, marvalid_fp, mrready_fp;
  logic [5:0]       marid_rr, marid_fp;
  logic [7:0]       maraddr_rr, marlen_rr, maraddr_fp, marlen_fp;
  logic [2:0]       marsize_rr, marsize_fp;
  logic [1:0]       marburst_rr, marburst_fp;

  int checks = 0;
  int failures = 0;

  svc_axi_arbiter_rd_qos #(.ARB_MODE(0)) u_rr (
    .clk(clk), .rst(rst),
    .s_axi_arvalid(arvalid), .s_axi_arid(arid), .s_axi_araddr(araddr),
    .s_axi_arlen(arlen), .s_axi_arsize(arsize), .s_axi_arburst(arburst),
    .s_axi_arready(arready_rr), .s_axi_rvalid(rvalid_rr), .s_axi_rid(rid_rr),
    .s_axi_rdata(rdata_rr), .s_axi_rresp(rresp_rr), .s_axi_rlast(rlast_rr),
    .s_axi_rready(rready_s),
    .m_axi_arvalid(marvalid_rr), .m_axi_arid(marid_rr), .m_axi_araddr(maraddr_rr),
    .m_axi_arlen(marlen_rr), .m_axi_arsize(marsize_rr), .m_axi_arburst(marburst_rr),
    .m_axi_arready(m_arready), .m_axi_rvalid(m_rvalid), .m_axi_rid(m_rid),
    .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rlast(m_rlast),
    .m_axi_rready(mrready_rr)
  );

  svc_axi_arbiter_rd_qos #(.ARB_MODE(1)) u_fp (
    .clk(clk), .rst(rst),
    .s_axi_arvalid(arvalid), .s_axi_arid(arid), .s_axi_araddr(araddr),
    .s_axi_arlen(arlen), .s_axi_arsize(arsize), .s_axi_arburst(arburst),
    .s_axi_arready(arready_fp), .s_axi_rvalid(rvalid_fp), .s_axi_rid(rid_fp),
    .s_axi_rdata(rdata_fp), .s_axi_rresp(rresp_fp), .s_axi_rlast(rlast_fp),
    .s_axi_rready(rready_s),
    .m_axi_arvalid(marvalid_fp), .m_axi_arid(marid_fp), .m_axi_araddr(maraddr_fp),
    .m_axi_arlen(marlen_fp), .m_axi_arsize(marsize_fp), .m_axi_arburst(marburst_fp),
    .m_axi_arready(m_arready), .m_axi_rvalid(m_rvalid), .m_axi_rid(m_rid),
    .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rlast(m_rlast),
    .m_axi_rready(mrready_fp)
  );

  task automatic do_reset();
    rst = 1'b1; arvalid = '0; m_arready = 1'b1; m_rvalid = 1'b0; m_rlast = 1'b0;
    m_rid = '0; m_rdata = '0; m_rresp = '0; rready_s = 4'hF;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; arvalid = 4'hF; m_arready = 1'b1; m_rvalid = 1'b1; m_rid = {2'd1, 4'h0};
    repeat (2) @(negedge clk);
    #1;
    checks++; if (marvalid_rr !== 1'b0) begin failures++; $display("FAIL reset_arvalid got=%0h exp=0", marvalid_rr); end
    checks++; if (maraddr_rr !== 8'h00 || marid_rr !== 6'h00 || marlen_rr !== 8'h00) begin failures++; $display("FAIL reset_payload got addr=%0h id=%0h len=%0h exp=0", maraddr_rr, marid_rr, marlen_rr); end
    checks++; if (arready_rr !== 4'h0 || arready_fp !== 4'h0) begin failures++; $display("FAIL reset_arready got=%0h/%0h exp=0", arready_rr, arready_fp); end
    checks++; if (rvalid_rr !== 4'h0) begin failures++; $display("FAIL reset_rvalid got=%0h exp=0", rvalid_rr); end
    do_reset();
  endtask

  task automatic test_rr_fairness();
    int j;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); arvalid = 4'hF; m_arready = 1'b1; #1;
      checks++; if (arready_rr !== 4'(1 << (k % 4))) begin failures++; $display("FAIL rr_grant k=%0d got=%0h exp=%0h", k, arready_rr, 4'(1 << (k % 4))); end
      if (k > 0) begin
        j = (k - 1) % 4;
        checks++; if (marvalid_rr !== 1'b1 || marid_rr !== {2'(j), 4'(j + 5)} || maraddr_rr !== 8'(16 * (j + 1))) begin
          failures++; $display("FAIL rr_ar_out k=%0d got v=%0h id=%0h addr=%0h exp v=1 id=%0h addr=%0h", k, marvalid_rr, marid_rr, maraddr_rr, {2'(j), 4'(j + 5)}, 8'(16 * (j + 1)));
        end
      end
    end
    arvalid = '0;
  endtask

  task automatic test_fixed_priority();
    logic [3:0] exp;
    logic [1:0] exp_idx;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      @(negedge clk); arvalid = 4'b1010; #1;
      exp = (k < 4) ? 4'b0010 : (k < 8) ? 4'b1000 : 4'b0000;
      checks++; if (arready_fp !== exp) begin failures++; $display("FAIL fp_grant k=%0d got=%0h exp=%0h", k, arready_fp, exp); end
      if (k >= 1) begin
        exp_idx = (k - 1 < 4) ? 2'd1 : 2'd3;
        checks++; if (marid_fp[5:4] !== exp_idx) begin failures++; $display("FAIL fp_arid k=%0d got=%0h exp=%0h", k, marid_fp[5:4], exp_idx); end
      end
    end
    arvalid = '0;
  endtask

  task automatic test_credit_limit();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); arvalid = 4'b0100; #1;
      checks++; if (arready_rr !== ((k < 4) ? 4'b0100 : 4'b0000)) begin failures++; $display("FAIL credit_grant k=%0d got=%0h exp=%0h", k, arready_rr, (k < 4) ? 4'b0100 : 4'b0000); end
    end
    checks++; if (marvalid_rr !== 1'b0) begin failures++; $display("FAIL credit_idle_arvalid got=%0h exp=0", marvalid_rr); end
    @(negedge clk); m_rvalid = 1'b1; m_rid = {2'd2, 4'h3}; m_rlast = 1'b1; #1;
    checks++; if (rvalid_rr !== 4'b0100 || mrready_rr !== 1'b1 || arready_rr !== 4'b0000) begin
      failures++; $display("FAIL credit_rbeat got rv=%0h rr=%0h ar=%0h exp rv=4 rr=1 ar=0", rvalid_rr, mrready_rr, arready_rr);
    end
    @(negedge clk); m_rvalid = 1'b0; m_rlast = 1'b0; #1;
    checks++; if (arready_rr !== 4'b0100) begin failures++; $display("FAIL credit_unblock got=%0h exp=4", arready_rr); end
    @(negedge clk); #1;
    checks++; if (arready_rr !== 4'b0000) begin failures++; $display("FAIL credit_reblock got=%0h exp=0", arready_rr); end
    arvalid = '0;
  endtask

  task automatic test_stall_hold();
    do_reset();
    @(negedge clk); arvalid = 4'b0011; m_arready = 1'b0; #1;
    checks++; if (arready_rr !== 4'b0001) begin failures++; $display("FAIL stall_first got=%0h exp=1", arready_rr); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      checks++; if (marvalid_rr !== 1'b1 || maraddr_rr !== 8'h10 || marid_rr !== {2'd0, 4'h5} || arready_rr !== 4'h0) begin
        failures++; $display("FAIL stall_hold k=%0d got v=%0h addr=%0h id=%0h ar=%0h exp v=1 addr=10 id=05 ar=0", k, marvalid_rr, maraddr_rr, marid_rr, arready_rr);
      end
    end
    @(negedge clk); m_arready = 1'b1; #1;
    checks++; if (arready_rr !== 4'b0010) begin failures++; $display("FAIL stall_release got=%0h exp=2", arready_rr); end
    @(negedge clk); arvalid = '0; #1;
    checks++; if (maraddr_rr !== 8'h20 || marid_rr !== {2'd1, 4'h6}) begin failures++; $display("FAIL stall_next got addr=%0h id=%0h exp addr=20 id=16", maraddr_rr, marid_rr); end
  endtask

  task automatic test_r_routing();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); arvalid = 4'b1000;
    end
    @(negedge clk); #1;
    checks++; if (arready_rr !== 4'h0) begin failures++; $display("FAIL route_full got=%0h exp=0", arready_rr); end
    @(negedge clk); m_rvalid = 1'b1; m_rid = {2'd3, 4'hA}; m_rdata = 16'h1234; m_rresp = 2'b10; m_rlast = 1'b0; rready_s = 4'hF; #1;
    checks++; if (rvalid_rr !== 4'b1000 || rdata_rr[3] !== 16'h1234 || rresp_rr[3] !== 2'b10) begin
      failures++; $display("FAIL route_beat got rv=%0h data=%0h resp=%0h exp rv=8 data=1234 resp=2", rvalid_rr, rdata_rr[3], rresp_rr[3]);
    end
    @(negedge clk); m_rlast = 1'b1; m_rdata = 16'hBEEF; rready_s = 4'b0111; #1;
    checks++; if (arready_rr !== 4'h0) begin failures++; $display("FAIL route_nonlast_dec got=%0h exp=0", arready_rr); end
    checks++; if (rvalid_rr !== 4'b1000 || rid_rr[3] !== 4'hA || rdata_rr[3] !== 16'hBEEF || rlast_rr[3] !== 1'b1 || mrready_rr !== 1'b0) begin
      failures++; $display("FAIL route_last got rv=%0h id=%0h data=%0h last=%0h rr=%0h exp rv=8 id=a data=beef last=1 rr=0", rvalid_rr, rid_rr[3], rdata_rr[3], rlast_rr[3], mrready_rr);
    end
    @(negedge clk); #1;
    checks++; if (mrready_rr !== 1'b0 || arready_rr !== 4'h0) begin failures++; $display("FAIL route_backpressure got rr=%0h ar=%0h exp rr=0 ar=0", mrready_rr, arready_rr); end
    @(negedge clk); rready_s = 4'hF; #1;
    checks++; if (mrready_rr !== 1'b1) begin failures++; $display("FAIL route_release got=%0h exp=1", mrready_rr); end
    @(negedge clk); m_rvalid = 1'b0; m_rlast = 1'b0; #1;
    checks++; if (arready_rr !== 4'b1000) begin failures++; $display("FAIL route_decrement got=%0h exp=8", arready_rr); end
    arvalid = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); arvalid = 4'b0001;
    end
    @(negedge clk); rst = 1'b1; #1;
    checks++; if (marvalid_rr !== 1'b1 || arready_rr !== 4'h0) begin failures++; $display("FAIL mid_pre got v=%0h ar=%0h exp v=1 ar=0", marvalid_rr, arready_rr); end
    @(negedge clk); #1;
    checks++; if (marvalid_rr !== 1'b0 || maraddr_rr !== 8'h00) begin failures++; $display("FAIL mid_clear got v=%0h addr=%0h exp 0", marvalid_rr, maraddr_rr); end
    @(negedge clk); rst = 1'b0; arvalid = 4'hF; #1;
    checks++; if (arready_rr !== 4'b0001) begin failures++; $display("FAIL mid_first got=%0h exp=1", arready_rr); end
    @(negedge clk); #1;
    checks++; if (arready_rr !== 4'b0010) begin failures++; $display("FAIL mid_second got=%0h exp=2", arready_rr); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); arvalid = 4'b0001; #1;
      checks++; if (arready_rr !== ((k < 3) ? 4'b0001 : 4'b0000)) begin failures++; $display("FAIL mid_credit k=%0d got=%0h exp=%0h", k, arready_rr, (k < 3) ? 4'b0001 : 4'b0000); end
    end
    arvalid = '0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      arid[i]    = 4'(i + 5);
      araddr[i]  = 8'(16 * (i + 1));
      arlen[i]   = 8'(i + 1);
      arsize[i]  = 3'd1;
      arburst[i] = 2'b01;
    end
    test_reset();
    test_rr_fairness();
    test_fixed_priority();
    test_credit_limit();
    test_stall_hold();
    test_r_routing();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
